// File: rtl/bombe_rotor_sequencer_pkg.sv
// ============================================================================
// bombe_rotor_sequencer_pkg -- shared rotor width, FSM states and step helper
// Rev 1.0
// ============================================================================
`default_nettype none

package bombe_rotor_sequencer_pkg;

  localparam int c_rotor_w = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_TEST   = 3'd3,
    ST_STEP   = 3'd4,
    ST_HALT   = 3'd5,
    ST_DONE   = 3'd6
  } seq_state_t;

  // Number of distinct bank positions, i.e. steps in one full odometer cycle.
  function automatic int max_steps(input int alphabet, input int num_rotors);
    int r;
    r = 1;
    for (int i = 0; i < num_rotors; i++) r = r * alphabet;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bombe_rotor_sequencer_rotor_counter.sv
// ============================================================================
// bombe_rotor_sequencer_rotor_counter -- mod-ALPHABET shadow of one rotor
// Rev 1.0
// ============================================================================
`default_nettype none

module bombe_rotor_sequencer_rotor_counter
  import bombe_rotor_sequencer_pkg::*;
#(
  parameter int ALPHABET = 26
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 inc,
  input  logic [c_rotor_w-1:0] load_val,
  output logic [c_rotor_w-1:0] pos,
  output logic                 at_wrap
);

  logic [c_rotor_w-1:0] r_pos;

  assign pos     = r_pos;
  assign at_wrap = (r_pos == c_rotor_w'(ALPHABET - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pos <= '0;
    end else if (load) begin
      r_pos <= load_val;
    end else if (inc) begin
      r_pos <= at_wrap ? '0 : r_pos + c_rotor_w'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bombe_rotor_sequencer.sv
// ============================================================================
// bombe_rotor_sequencer -- steps the rotor bank odometer-style, offers tests
// Rev 1.0
// ============================================================================
`default_nettype none

module bombe_rotor_sequencer
  import bombe_rotor_sequencer_pkg::*;
#(
  parameter int NUM_ROTORS    = 3,
  parameter int ALPHABET      = 26,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            resume,
  input  logic [c_rotor_w*NUM_ROTORS-1:0] init_state,
  output logic                            rotor_load,
  output logic [NUM_ROTORS-1:0]           rotor_inc,
  output logic [c_rotor_w*NUM_ROTORS-1:0] position,
  output logic                            test_valid,
  input  logic                            test_ready,
  input  logic                            stop_hit,
  output logic                            busy,
  output logic                            found,
  output logic [c_rotor_w*NUM_ROTORS-1:0] found_position,
  output logic                            done
);

  localparam int c_pos_w     = c_rotor_w * NUM_ROTORS;
  localparam int c_max_steps = max_steps(ALPHABET, NUM_ROTORS);
  localparam int c_step_w    = $clog2(c_max_steps + 1);
  localparam int c_settle_w  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_t              r_state;
  logic [c_step_w-1:0]     r_steps;
  logic [c_settle_w-1:0]   r_settle_cnt;
  logic                    r_rotor_load;
  logic [NUM_ROTORS-1:0]   r_rotor_inc;
  logic                    r_test_valid;
  logic                    r_busy;
  logic                    r_found;
  logic [c_pos_w-1:0]      r_found_position;
  logic                    r_done;

  logic [NUM_ROTORS-1:0]   w_at_wrap;
  logic [NUM_ROTORS-1:0]   w_carry;
  logic [c_step_w-1:0]     w_steps_next;
  logic                    w_unused_top_wrap;

  generate
    for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor
      bombe_rotor_sequencer_rotor_counter #(
        .ALPHABET (ALPHABET)
      ) u_counter (
        .clk      (clk),
        .resetn   (resetn),
        .load     (r_rotor_load),
        .inc      (r_rotor_inc[i]),
        .load_val (init_state[c_rotor_w*i +: c_rotor_w]),
        .pos      (position[c_rotor_w*i +: c_rotor_w]),
        .at_wrap  (w_at_wrap[i])
      );
    end
  endgenerate

  // Rotor i advances only when every faster rotor is about to wrap.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = 1'b1;
    for (int i = 1; i < NUM_ROTORS; i++) w_carry[i] = w_carry[i-1] & w_at_wrap[i-1];
  end

  // The slowest rotor has nothing above it to carry into.
  assign w_unused_top_wrap = w_at_wrap[NUM_ROTORS-1];
  assign w_steps_next      = r_steps + c_step_w'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= ST_IDLE;
      r_steps          <= '0;
      r_settle_cnt     <= '0;
      r_rotor_load     <= 1'b0;
      r_rotor_inc      <= '0;
      r_test_valid     <= 1'b0;
      r_busy           <= 1'b0;
      r_found          <= 1'b0;
      r_found_position <= '0;
      r_done           <= 1'b0;
    end else begin
      r_rotor_load <= 1'b0;
      r_rotor_inc  <= '0;
      if (abort) begin
        r_state      <= ST_IDLE;
        r_test_valid <= 1'b0;
        r_busy       <= 1'b0;
        r_done       <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              r_state      <= ST_LOAD;
              r_rotor_load <= 1'b1;
              r_busy       <= 1'b1;
              r_done       <= 1'b0;
            end
          end
          ST_LOAD: begin
            r_steps      <= '0;
            r_found      <= 1'b0;
            r_settle_cnt <= '0;
            r_state      <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (r_settle_cnt == c_settle_w'(SETTLE_CYCLES - 1)) begin
              r_state      <= ST_TEST;
              r_test_valid <= 1'b1;
            end else begin
              r_settle_cnt <= r_settle_cnt + c_settle_w'(1);
            end
          end
          ST_TEST: begin
            if (test_ready) begin
              r_test_valid <= 1'b0;
              if (stop_hit) begin
                r_found          <= 1'b1;
                r_found_position <= position;
                r_busy           <= 1'b0;
                r_state          <= ST_HALT;
              end else begin
                r_rotor_inc <= w_carry;
                r_state     <= ST_STEP;
              end
            end
          end
          ST_STEP: begin
            r_steps      <= w_steps_next;
            r_settle_cnt <= '0;
            if (w_steps_next == c_step_w'(c_max_steps)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SETTLE;
            end
          end
          ST_HALT: begin
            if (resume) begin
              r_rotor_inc <= w_carry;
              r_busy      <= 1'b1;
              r_state     <= ST_STEP;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rotor_load     = r_rotor_load;
  assign rotor_inc      = r_rotor_inc;
  assign test_valid     = r_test_valid;
  assign busy           = r_busy;
  assign found          = r_found;
  assign found_position = r_found_position;
  assign done           = r_done;

endmodule

`default_nettype wire
